// File: rtl/esn7e_demo_system_nios2_qsys_oci_dct_packer_pkg.sv
// Shared definitions for the DCT trace packer: FSM state encodings and
// the width and update rule of the saturating overflow counter.
package esn7e_demo_system_nios2_qsys_oci_dct_packer_pkg;

    localparam int OVF_W = 16;

    typedef enum logic [1:0] {
        DCT_RUN   = 2'd0,
        DCT_DRAIN = 2'd1,
        DCT_ENDED = 2'd2
    } dct_state_e;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/esn7e_demo_system_nios2_qsys_oci_dct_packer_fifo.sv
// Registered synchronous FIFO, first-word-fall-through from storage.
// A push into a full FIFO succeeds when a pop happens on the same edge.
module esn7e_demo_system_nios2_qsys_oci_dct_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero while empty so stale storage never leaks out.
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the level counter alone decides
    // which entries are meaningful, and empty reads are masked above.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/esn7e_demo_system_nios2_qsys_oci_dct_packer.sv
// DCT trace packer: packs narrow entries LSB-first into words, queues them in
// an output FIFO and, on test end, flushes and drains before signalling done.
module esn7e_demo_system_nios2_qsys_oci_dct_packer
    import esn7e_demo_system_nios2_qsys_oci_dct_packer_pkg::*;
#(
    parameter int ENTRY_W    = 2,
    parameter int ENTRIES    = 15,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [ENTRY_W-1:0]            in_data,
    input  logic                          test_ending,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ENTRY_W*ENTRIES-1:0]    out_data,
    output logic [CNT_W-1:0]              out_count,
    output logic [ENTRY_W*ENTRIES-1:0]    dct_buffer,
    output logic [CNT_W-1:0]              dct_count,
    output logic [OVF_W-1:0]              overflow_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          test_has_ended
);

    localparam int WORD_W = ENTRY_W * ENTRIES;

    dct_state_e         state_q;
    logic [WORD_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OVF_W-1:0]   ovf_q;
    logic               ended_q;
    logic               accept, flush, push, pop, fifo_full, fifo_empty;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        accept = (state_q == DCT_RUN) && in_valid;
        flush  = (state_q == DCT_RUN) && test_ending;
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        if (accept) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (CNT_W'(i) == cnt_q) buf_d[i*ENTRY_W +: ENTRY_W] = in_data;
            end
            cnt_d = cnt_q + 1'b1;
        end
        // The entry accepted alongside a flush is part of the flushed word.
        push = (cnt_d == CNT_W'(ENTRIES)) || (flush && cnt_d != '0);
    end

    assign pop = out_valid && out_ready;

    esn7e_demo_system_nios2_qsys_oci_dct_fifo #(
        .WIDTH (WORD_W + CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i ({cnt_d, buf_d}),
        .pop_i       (pop),
        .pop_data_o  ({out_count, out_data}),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DCT_RUN;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
            ended_q <= 1'b0;
        end else begin
            ended_q <= (state_q == DCT_ENDED);
            if (push && fifo_full && !pop) ovf_q <= sat_inc(ovf_q);
            unique case (state_q)
                DCT_RUN: begin
                    // A dropped word still clears the accumulator.
                    if (push || flush) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        buf_q <= buf_d;
                        cnt_q <= cnt_d;
                    end
                    if (flush) state_q <= DCT_DRAIN;
                end
                DCT_DRAIN: if (fifo_empty) state_q <= DCT_ENDED;
                DCT_ENDED: state_q <= DCT_ENDED;
                default:   state_q <= DCT_RUN;
            endcase
        end
    end

    assign out_valid      = !fifo_empty;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign overflow_cnt   = ovf_q;
    assign test_has_ended = ended_q;

endmodule

// File: tb/tb_esn7e_demo_system_nios2_qsys_oci_dct_packer.sv
// Directed bench for the DCT packer with hand-computed expectations.
module tb_esn7e_demo_system_nios2_qsys_oci_dct_packer;

    logic        clk, reset_n, in_valid, test_ending, out_ready;
    logic [1:0]  in_data;
    logic        out_valid, test_has_ended;
    logic [29:0] out_data, dct_buffer;
    logic [3:0]  out_count, dct_count;
    logic [15:0] overflow_cnt;
    logic [2:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    esn7e_demo_system_nios2_qsys_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .test_ending    (test_ending),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow_cnt   (overflow_cnt),
        .fifo_level     (fifo_level),
        .test_has_ended (test_has_ended)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
    endtask

    task automatic apply_reset();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_data     = 2'b00;
        test_ending = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    function automatic logic [29:0] word_of(input logic [1:0] v);
        return {15{v}};
    endfunction

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({out_valid, out_data, out_count, dct_buffer, dct_count, overflow_cnt,
             fifo_level, test_has_ended} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b data=%h cnt=%0d buf=%h dcnt=%0d ovf=%0d lvl=%0d end=%b required all zero",
                     out_valid, out_data, out_count, dct_buffer, dct_count, overflow_cnt, fifo_level, test_has_ended);
        end
    endtask

    task automatic test_full_word();
        apply_reset();
        out_ready = 1'b1;
        repeat (7) send(2'b01);
        checks++;
        if (dct_count !== 4'd7 || dct_buffer !== 30'h1555) begin
            failures++;
            $display("FAIL partial_accum got cnt=%0d buf=%h required cnt=7 buf=00001555", dct_count, dct_buffer);
        end
        repeat (7) send(2'b01);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL early_valid got %b required 0", out_valid);
        end
        send(2'b01);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 30'h15555555 || out_count !== 4'd15) begin
            failures++;
            $display("FAIL full_word got valid=%b data=%h cnt=%0d required 1 15555555 15", out_valid, out_data, out_count);
        end
        checks++;
        if (dct_count !== 4'd0 || dct_buffer !== 30'h0) begin
            failures++;
            $display("FAIL buf_clear got cnt=%0d buf=%h required 0 0", dct_count, dct_buffer);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 30'h0 || out_count !== 4'd0) begin
            failures++;
            $display("FAIL one_cycle_valid got valid=%b data=%h cnt=%0d required 0 0 0", out_valid, out_data, out_count);
        end
    endtask

    task automatic test_flush();
        int waited;
        apply_reset();
        send(2'b11);
        send(2'b10);
        send(2'b01);
        in_valid = 1'b0;
        checks++;
        if (dct_count !== 4'd3 || dct_buffer !== 30'h1B) begin
            failures++;
            $display("FAIL flush_accum got cnt=%0d buf=%h required 3 0000001b", dct_count, dct_buffer);
        end
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 30'h1B || out_count !== 4'd3 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL flush_word got valid=%b data=%h cnt=%0d dcnt=%0d required 1 0000001b 3 0",
                     out_valid, out_data, out_count, dct_count);
        end
        step();
        checks++;
        if (out_data !== 30'h1B || out_count !== 4'd3 || test_has_ended !== 1'b0) begin
            failures++;
            $display("FAIL flush_hold got data=%h cnt=%0d end=%b required 0000001b 3 0", out_data, out_count, test_has_ended);
        end
        out_ready = 1'b1;
        waited = 0;
        while (test_has_ended !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (test_has_ended !== 1'b1 || overflow_cnt !== 16'd0 || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL flush_end got end=%b ovf=%0d lvl=%0d required 1 0 0", test_has_ended, overflow_cnt, fifo_level);
        end
    endtask

    task automatic test_overflow();
        int popped;
        logic [1:0] v;
        apply_reset();
        for (int w = 0; w < 6; w++) begin
            v = 2'(w + 1);
            repeat (15) send(v);
        end
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || overflow_cnt !== 16'd2) begin
            failures++;
            $display("FAIL overflow_fill got lvl=%0d ovf=%0d required 4 2", fifo_level, overflow_cnt);
        end
        out_ready = 1'b1;
        popped = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid === 1'b1) begin
                v = 2'(popped + 1);
                checks++;
                if (popped >= 4 || out_data !== word_of(v) || out_count !== 4'd15) begin
                    failures++;
                    $display("FAIL drain_order idx=%0d got data=%h cnt=%0d required %h 15",
                             popped, out_data, out_count, word_of(v));
                end
                popped++;
            end
            step();
        end
        checks++;
        if (popped !== 4) begin
            failures++;
            $display("FAIL drain_count got %0d required 4", popped);
        end
    endtask

    task automatic test_push_pop_full();
        logic [1:0] v;
        apply_reset();
        for (int w = 0; w < 4; w++) begin
            v = 2'(w + 1);
            repeat (15) send(v);
        end
        repeat (14) send(2'b01);
        out_ready = 1'b1;
        send(2'b01);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (overflow_cnt !== 16'd0 || fifo_level !== 3'd4 || out_data !== 30'h2AAAAAAA) begin
            failures++;
            $display("FAIL push_pop_full got ovf=%0d lvl=%0d head=%h required 0 4 2aaaaaaa",
                     overflow_cnt, fifo_level, out_data);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        apply_reset();
        repeat (37) send(2'b11);
        in_valid = 1'b0;
        checks++;
        if (dct_count !== 4'd7 || fifo_level !== 3'd2) begin
            failures++;
            $display("FAIL mid_setup got cnt=%0d lvl=%0d required 7 2", dct_count, fifo_level);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_count, dct_buffer, dct_count, overflow_cnt,
             fifo_level, test_has_ended} !== '0) begin
            failures++;
            $display("FAIL mid_reset got valid=%b data=%h buf=%h dcnt=%0d lvl=%0d required all zero",
                     out_valid, out_data, dct_buffer, dct_count, fifo_level);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || dct_count !== 4'd0) begin
            failures++;
            $display("FAIL stale_after_reset got seen=%b dcnt=%0d required 0 0", seen, dct_count);
        end
    endtask

    task automatic test_end_empty();
        apply_reset();
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        checks++;
        if (test_has_ended !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL end_empty_s0 got end=%b valid=%b required 0 0", test_has_ended, out_valid);
        end
        step();
        checks++;
        if (test_has_ended !== 1'b0) begin
            failures++;
            $display("FAIL end_empty_s1 got %b required 0", test_has_ended);
        end
        step();
        checks++;
        if (test_has_ended !== 1'b1) begin
            failures++;
            $display("FAIL end_empty_s2 got %b required 1", test_has_ended);
        end
        test_ending = 1'b1;
        repeat (5) send(2'b11);
        in_valid    = 1'b0;
        test_ending = 1'b0;
        step();
        checks++;
        if (dct_count !== 4'd0 || out_valid !== 1'b0 || fifo_level !== 3'd0 || test_has_ended !== 1'b1) begin
            failures++;
            $display("FAIL ended_ignores got dcnt=%0d valid=%b lvl=%0d end=%b required 0 0 0 1",
                     dct_count, out_valid, fifo_level, test_has_ended);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_end_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
